// File: rtl/img_frame_packer.sv
// Purpose : frames RGB565 camera pixels as 0x00RRGGBB words between a header and a trailer word.
// Latency : an accepted pixel reaches fifo_wr_en on the next cycle when the FIFO is not full.
// Backpressure: one-word output register; img_ready drops while the register is held by fifo_full.
module img_frame_packer #(
   parameter int unsigned EXP_PIXELS = 307200,  // expected pixels per frame, 0 disables the size check
   parameter int unsigned CNT_W      = 20       // saturating pixel counter width, at most 20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        img_valid,
   input  logic        img_sync,
   input  logic [15:0] img_data,
   output logic        img_ready,
   input  logic        fifo_full,
   output logic        fifo_wr_en,
   output logic [31:0] fifo_din,
   output logic [15:0] frame_count,
   output logic [15:0] drop_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PASS    = 2'd2,
      TRAILER = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state;
   state_t             state_nxt;

   // one-word output register
   logic [31:0]        out_word;
   logic               out_vld;

   // per-frame bookkeeping
   logic [CNT_W-1:0]   pix_cnt;
   logic               ovr;
   logic               mis;
   logic               keep_en;     // enable as seen at the frame-ending sync

   // decoded per-cycle actions
   logic               reg_free;
   logic               load_en;
   logic [31:0]        load_word;
   logic               hdr_load;
   logic               pix_acc;
   logic               ovr_set;
   logic               drop_inc;
   logic               keep_set;
   logic [31:0]        pix_word;
   logic [31:0]        hdr_word;
   logic [31:0]        trl_word;

   // The register can take a new word when empty or when its current word drains this cycle.
   assign reg_free   = ~out_vld | ~fifo_full;
   assign fifo_wr_en = out_vld & ~fifo_full;
   assign fifo_din   = out_word;

   // Size mismatch only meaningful when an expected size is configured.
   assign mis = (EXP_PIXELS != 0) && (32'(pix_cnt) != 32'(EXP_PIXELS));

   // 5/6-bit channels widened to 8 bits by replicating their MSBs into the low bits.
   assign pix_word = {8'h00,
                      img_data[15:11], img_data[15:13],
                      img_data[10:5],  img_data[10:9],
                      img_data[4:0],   img_data[4:2]};
   assign hdr_word = {8'hFF, 8'h00, frame_count};
   assign trl_word = {8'hFE, 2'b00, ovr, mis, 20'(pix_cnt)};

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, handshake and output-register load decisions.
   always_comb begin
      state_nxt = state;
      img_ready = 1'b0;
      load_en   = 1'b0;
      load_word = pix_word;
      hdr_load  = 1'b0;
      pix_acc   = 1'b0;
      ovr_set   = 1'b0;
      drop_inc  = 1'b0;
      keep_set  = 1'b0;
      case (state)
         IDLE: begin
            // Pixels outside a frame are swallowed so the camera never stalls.
            img_ready = 1'b1;
            if (img_sync && enable) begin
               state_nxt = HEADER;
            end
         end
         HEADER: begin
            if (img_sync) begin
               drop_inc = 1'b1;
            end
            if (reg_free) begin
               load_en   = 1'b1;
               load_word = hdr_word;
               hdr_load  = 1'b1;
               state_nxt = PASS;
            end
         end
         PASS: begin
            // A sync closes the frame, so a pixel arriving with it belongs to no frame.
            img_ready = reg_free & ~img_sync;
            if (img_valid && img_ready) begin
               load_en   = 1'b1;
               load_word = pix_word;
               pix_acc   = 1'b1;
            end
            if (img_valid && !img_ready && !img_sync) begin
               ovr_set = 1'b1;
            end
            if (img_sync) begin
               keep_set  = 1'b1;
               state_nxt = TRAILER;
            end
         end
         TRAILER: begin
            if (img_sync) begin
               drop_inc = 1'b1;
            end
            if (reg_free) begin
               load_en   = 1'b1;
               load_word = trl_word;
               state_nxt = keep_en ? HEADER : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output register: a load wins over a drain so a word can be replaced in the cycle it is written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_word <= 32'h0;
         out_vld  <= 1'b0;
      end else if (load_en) begin
         out_word <= load_word;
         out_vld  <= 1'b1;
      end else if (fifo_wr_en) begin
         out_vld  <= 1'b0;
      end
   end

   // Pixel count, overrun flag and the enable captured at the closing sync.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_cnt <= '0;
         ovr     <= 1'b0;
         keep_en <= 1'b0;
      end else begin
         if (hdr_load) begin
            pix_cnt <= '0;
            ovr     <= 1'b0;
         end else begin
            if (pix_acc && (pix_cnt != CNT_MAX)) begin
               pix_cnt <= pix_cnt + 1'b1;
            end
            if (ovr_set) begin
               ovr <= 1'b1;
            end
         end
         if (keep_set) begin
            keep_en <= enable;
         end
      end
   end

   // Wrapping status counters: headers emitted and syncs ignored mid-framing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count <= 16'h0;
         drop_count  <= 16'h0;
      end else begin
         if (hdr_load) begin
            frame_count <= frame_count + 16'h1;
         end
         if (drop_inc) begin
            drop_count <= drop_count + 16'h1;
         end
      end
   end

endmodule

// File: tb/tb_img_frame_packer.sv
// Bench for img_frame_packer: expected FIFO words are queued as stimulus is driven
// and compared in order as the packer writes them; counters and handshake checked directly.
module tb_img_frame_packer;

   localparam int EXP = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        img_valid;
   logic        img_sync;
   logic [15:0] img_data;
   logic        img_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [31:0] fifo_din;
   logic [15:0] frame_count;
   logic [15:0] drop_count;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   // reference model of framing state
   int          fc_exp;
   int          drop_exp;
   int          cnt_exp;
   bit          ovr_exp;
   bit          active;

   always #5 clk = ~clk;

   img_frame_packer #(.EXP_PIXELS(EXP), .CNT_W(20)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .img_valid   (img_valid),
      .img_sync    (img_sync),
      .img_data    (img_data),
      .img_ready   (img_ready),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_din    (fifo_din),
      .frame_count (frame_count),
      .drop_count  (drop_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] px(input logic [15:0] d);
      logic [7:0] r, g, b;
      r = {d[15:11], d[15:13]};
      g = {d[10:5], d[10:9]};
      b = {d[4:0], d[4:2]};
      return {8'h00, r, g, b};
   endfunction

   function automatic logic [31:0] hdr(input int fc);
      return {16'hFF00, 16'(fc)};
   endfunction

   function automatic logic [31:0] trl(input int cnt, input bit ovr);
      bit mis;
      mis = (EXP != 0) && (cnt != EXP);
      return {8'hFE, 2'b00, ovr, mis, 20'(cnt)};
   endfunction

   // Every FIFO write must match the oldest queued word; nothing may be written into a full FIFO.
   always @(negedge clk) begin
      if (reset_n) begin
         if (fifo_full) begin
            check_eq("wr_while_full", 32'(fifo_wr_en), 32'd0);
         end
         if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_wr", 32'(fifo_wr_en), 32'd0);
            end else begin
               check_eq("word", fifo_din, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pixel(input logic [15:0] d);
      bit ok;
      ok = 1'b0;
      img_data  = d;
      img_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (img_ready) begin
            exp_q.push_back(px(d));
            cnt_exp++;
            ok = 1'b1;
            @(posedge clk);
            #1;
            break;
         end
      end
      if (!ok) begin
         check_eq("pix_timeout", 32'(img_ready), 32'd1);
      end
      img_valid = 1'b0;
   endtask

   // Sync that the model expects the packer to act on.
   task automatic frame_sync(input bit en);
      enable   = en;
      img_sync = 1'b1;
      if (!active) begin
         if (en) begin
            exp_q.push_back(hdr(fc_exp));
            fc_exp++;
            cnt_exp = 0;
            ovr_exp = 1'b0;
            active  = 1'b1;
         end
      end else begin
         exp_q.push_back(trl(cnt_exp, ovr_exp));
         if (en) begin
            exp_q.push_back(hdr(fc_exp));
            fc_exp++;
            cnt_exp = 0;
            ovr_exp = 1'b0;
         end else begin
            active = 1'b0;
         end
      end
      tick();
      img_sync = 1'b0;
   endtask

   // Sync with no queued words; the caller states its effect on counters.
   task automatic raw_sync(input bit en);
      enable   = en;
      img_sync = 1'b1;
      tick();
      img_sync = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) break;
      end
      check_eq("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      img_valid = 1'b0;
      img_sync  = 1'b0;
      img_data  = 16'h0;
      fifo_full = 1'b0;
      fc_exp    = 0;
      drop_exp  = 0;
      cnt_exp   = 0;
      ovr_exp   = 1'b0;
      active    = 1'b0;

      #12;
      check_eq("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check_eq("rst_din", fifo_din, 32'd0);
      check_eq("rst_frame_count", 32'(frame_count), 32'd0);
      check_eq("rst_drop_count", 32'(drop_count), 32'd0);
      check_eq("rst_ready", 32'(img_ready), 32'd1);
      tick();
      reset_n = 1'b1;
      tick();

      // Frame of four colour-corner pixels, then the next frame starts.
      frame_sync(1'b1);
      send_pixel(16'hF800);
      send_pixel(16'h07E0);
      send_pixel(16'h001F);
      send_pixel(16'hFFFF);
      frame_sync(1'b1);
      drain();

      // Short frame; pixel presented together with the closing sync is neither taken nor an overrun.
      send_pixel(16'h1234);
      send_pixel(16'h8421);
      send_pixel(16'h0000);
      img_data  = 16'h5555;
      img_valid = 1'b1;
      frame_sync(1'b1);
      img_valid = 1'b0;
      drain();
      check_eq("short_frame_count", 32'(frame_count), 32'(fc_exp));

      // FIFO full for ten cycles with a pixel held.
      send_pixel(16'hA5A5);
      send_pixel(16'h5A5A);
      img_data  = 16'hC3C3;
      img_valid = 1'b1;
      fifo_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check_eq("ready_while_full", 32'(img_ready), 32'd0);
         end
         if (img_ready) begin
            exp_q.push_back(px(img_data));
            cnt_exp++;
         end else begin
            ovr_exp = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      img_valid = 1'b0;
      fifo_full = 1'b0;
      frame_sync(1'b1);
      drain();

      // Two syncs one cycle apart: the second lands in TRAILER and is dropped.
      frame_sync(1'b1);
      raw_sync(1'b1);
      drop_exp++;
      drain();
      check_eq("drop_count", 32'(drop_count), 32'(drop_exp));
      check_eq("frame_count_pair", 32'(frame_count), 32'(fc_exp));

      // Frame closed with enable low: trailer only, then idle pixels produce nothing.
      send_pixel(16'h0001);
      send_pixel(16'h0020);
      send_pixel(16'h0800);
      send_pixel(16'hFFE0);
      frame_sync(1'b0);
      drain();
      img_data  = 16'h7777;
      img_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("idle_ready", 32'(img_ready), 32'd1);
         @(posedge clk);
         #1;
      end
      img_valid = 1'b0;
      raw_sync(1'b0);
      repeat (10) tick();
      check_eq("idle_drop_count", 32'(drop_count), 32'(drop_exp));
      check_eq("idle_frame_count", 32'(frame_count), 32'(fc_exp));

      // Reset mid-frame with a word held by a full FIFO.
      frame_sync(1'b1);
      drain();
      send_pixel(16'hBEEF);
      fifo_full = 1'b1;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check_eq("mid_rst_din", fifo_din, 32'd0);
      check_eq("mid_rst_frame_count", 32'(frame_count), 32'd0);
      check_eq("mid_rst_drop_count", 32'(drop_count), 32'd0);
      check_eq("mid_rst_ready", 32'(img_ready), 32'd1);
      exp_q.delete();
      fc_exp   = 0;
      drop_exp = 0;
      cnt_exp  = 0;
      ovr_exp  = 1'b0;
      active   = 1'b0;
      tick();
      reset_n   = 1'b1;
      fifo_full = 1'b0;
      repeat (3) tick();
      frame_sync(1'b1);
      drain();
      check_eq("post_rst_frame_count", 32'(frame_count), 32'(fc_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
